// File: rtl/chunk_prefix_adder_seq_pkg.sv
// rtl/chunk_prefix_adder_seq_pkg.sv - shared constants, state type and sizing helpers for the chunked adder
package chunk_prefix_adder_seq_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nchunk_f(input int width);
    return width / CHUNK_W;
  endfunction

  // Index counter width; a single-chunk adder still needs a 1-bit counter.
  function automatic int idx_w_f(input int width);
    int n;
    n = width / CHUNK_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunk_pg_prefix4.sv
// rtl/chunk_pg_prefix4.sv - combinational 4-bit inclusive group propagate/generate prefix
module chunk_pg_prefix4
  import chunk_prefix_adder_seq_pkg::*;
(
  input  logic [CHUNK_W-1:0] p_in,
  input  logic [CHUNK_W-1:0] g_in,
  output logic [CHUNK_W-1:0] p_pre,
  output logic [CHUNK_W-1:0] g_pre
);

  logic pp0, pp1, pp2, pp3;
  logic gp0, gp1, gp2, gp3;

  assign pp0 = p_in[0];
  assign pp1 = p_in[1] & pp0;
  assign pp2 = p_in[2] & pp1;
  assign pp3 = p_in[3] & pp2;

  assign gp0 = g_in[0];
  assign gp1 = g_in[1] | (p_in[1] & gp0);
  assign gp2 = g_in[2] | (p_in[2] & gp1);
  assign gp3 = g_in[3] | (p_in[3] & gp2);

  assign p_pre = {pp3, pp2, pp1, pp0};
  assign g_pre = {gp3, gp2, gp1, gp0};

endmodule

// File: rtl/chunk_prefix_adder_seq.sv
// rtl/chunk_prefix_adder_seq.sv - multi-cycle adder, one 4-bit chunk per clock, LSB chunk first
module chunk_prefix_adder_seq
  import chunk_prefix_adder_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK  = CHUNK_W;
  localparam int NCHUNK = nchunk_f(WIDTH);
  localparam int IW     = idx_w_f(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             alive_q, alive_d;

  logic [CHUNK-1:0] p_bit, g_bit, p_pre, g_pre, c_vec, s_chunk;
  logic             c_next;
  logic [WIDTH+CHUNK-1:0] sum_ext;

  // Operand registers shift right each RUN cycle, so the active chunk is always the low nibble.
  assign p_bit = a_q[CHUNK-1:0] ^ b_q[CHUNK-1:0];
  assign g_bit = a_q[CHUNK-1:0] & b_q[CHUNK-1:0];

  chunk_pg_prefix4 u_prefix (
    .p_in  (p_bit),
    .g_in  (g_bit),
    .p_pre (p_pre),
    .g_pre (g_pre)
  );

  assign c_vec[0] = carry_q;
  assign c_vec[1] = g_pre[0] | (p_pre[0] & carry_q);
  assign c_vec[2] = g_pre[1] | (p_pre[1] & carry_q);
  assign c_vec[3] = g_pre[2] | (p_pre[2] & carry_q);
  assign c_next   = g_pre[3] | (p_pre[3] & carry_q);
  assign s_chunk  = p_bit ^ c_vec;
  assign sum_ext  = {s_chunk, sum_q};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    alive_d   = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = alive_q;
        if (in_valid && alive_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = sum_ext[WIDTH+CHUNK-1:CHUNK];
        carry_d = c_next;
        if (idx_q == LAST_IDX) begin
          cout_d  = c_next;
          ovf_d   = c_vec[3] ^ c_next;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // alive_q holds in_ready low during reset and releases it on the first edge afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      alive_q <= alive_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_chunk_prefix_adder_seq.sv
// tb/tb_chunk_prefix_adder_seq.sv - directed bench for the chunked adder at WIDTH=16 and WIDTH=4
module tb_chunk_prefix_adder_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [15:0] sum;

  logic        in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        in_ready4, out_valid4, cout4, ovf4;
  logic [3:0]  sum4;

  int errors = 0;
  int checks = 0;

  chunk_prefix_adder_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  chunk_prefix_adder_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  // Drives one operation on the 16-bit instance; lat is -1 if any wait expired.
  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                       output logic [15:0] s, output logic co, output logic ov, output int lat);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    a = av; b = bv; cin = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
    if (lat >= 30 || n >= 30) lat = -1;
    s = sum; co = cout; ov = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic ci,
                      output logic [3:0] s, output logic co, output logic ov, output int lat);
    int n;
    n = 0;
    while (in_ready4 !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    a4 = av; b4 = bv; cin4 = ci; in_valid4 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
    if (lat >= 30 || n >= 30) lat = -1;
    s = sum4; co = cout4; ov = ovf4;
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h want 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b want 00", {cout, ovf}); end
    rst = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_before_edge: in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_after_edge: in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_arith16;
    logic [15:0] va [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'h0FFF};
    logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h8000, 16'h4321, 16'h0000};
    logic        vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [5] = '{16'h0000, 16'h8000, 16'h0000, 16'h5556, 16'h1000};
    logic        eco[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        eov[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] s;
    logic        co, ov;
    int          lat;
    for (int k = 0; k < 5; k++) begin
      run16(va[k], vb[k], vc[k], s, co, ov, lat);
      checks++; if (s !== es[k]) begin errors++; $display("FAIL arith16_sum[%0d]: got %h want %h", k, s, es[k]); end
      checks++; if (co !== eco[k]) begin errors++; $display("FAIL arith16_cout[%0d]: got %b want %b", k, co, eco[k]); end
      checks++; if (ov !== eov[k]) begin errors++; $display("FAIL arith16_ovf[%0d]: got %b want %b", k, ov, eov[k]); end
      checks++; if (lat != 4) begin errors++; $display("FAIL arith16_latency[%0d]: got %0d want 4", k, lat); end
    end
  endtask

  task automatic test_backpressure;
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    a = 16'h0003; b = 16'h0004; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_latency: got %0d want 4", n); end
    a = 16'h0010; b = 16'h0020; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if ({sum, cout, ovf} !== {16'h0007, 2'b00}) begin errors++; $display("FAIL bp_result[%0d]: got %h/%b%b want 0007/00", k, sum, cout, ovf); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_pending_accept: in_ready=%b want 0", in_ready); end
    n = 0;
    while (out_valid !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    checks++; if (sum !== 16'h0030 || n != 4) begin errors++; $display("FAIL bp_pending_result: sum=%h lat=%0d want 0030 lat 4", sum, n); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun;
    logic [15:0] s;
    logic        co, ov;
    int          lat, n;
    run16(16'h8000, 16'h8000, 1'b0, s, co, ov, lat);
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL midrun_pre_cout: got %b want 1", co); end
    n = 0;
    while (in_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
    a = 16'hFFFF; b = 16'h0FFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_running: out_valid=%b want 0", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_rst_valid: got %b want 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL midrun_rst_sum: got %h want 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL midrun_rst_cout_ovf: got %b want 00", {cout, ovf}); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrun_rst_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL midrun_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    run16(16'h0001, 16'h0001, 1'b0, s, co, ov, lat);
    checks++; if ({s, co, ov} !== {16'h0002, 2'b00}) begin errors++; $display("FAIL midrun_fresh_add: got %h/%b%b want 0002/00", s, co, ov); end
    checks++; if (lat != 4) begin errors++; $display("FAIL midrun_fresh_latency: got %0d want 4", lat); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] av, bv, es;
    logic        ci, eco, eov;
    int          n, last;
    last = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
      av = 16'($urandom()); bv = 16'($urandom()); ci = 1'($urandom_range(0, 1));
      if (k == 0) begin av = 16'hFFF0; bv = 16'h0010; ci = 1'b0; end
      {eco, es} = {1'b0, av} + {1'b0, bv} + {16'h0000, ci};
      eov = (av[15] == bv[15]) && (es[15] != av[15]);
      a = av; b = bv; cin = ci;
      @(posedge clk); #1;
      n = 0;
      while (out_valid !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
      checks++; if ({sum, cout, ovf} !== {es, eco, eov}) begin errors++; $display("FAIL b2b16_result[%0d]: got %h/%b%b want %h/%b%b", k, sum, cout, ovf, es, eco, eov); end
      if (k > 0) begin
        checks++; if (cyc - last != 6) begin errors++; $display("FAIL b2b16_interval[%0d]: got %0d want 6", k, cyc - last); end
      end
      last = cyc;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_width4;
    logic [3:0] s;
    logic       co, ov;
    int         lat;
    run4(4'hF, 4'h1, 1'b0, s, co, ov, lat);
    checks++; if ({s, co, ov} !== {4'h0, 2'b10}) begin errors++; $display("FAIL w4_wrap: got %h/%b%b want 0/10", s, co, ov); end
    checks++; if (lat != 1) begin errors++; $display("FAIL w4_latency: got %0d want 1", lat); end
    run4(4'h7, 4'h1, 1'b0, s, co, ov, lat);
    checks++; if ({s, co, ov} !== {4'h8, 2'b01}) begin errors++; $display("FAIL w4_ovf: got %h/%b%b want 8/01", s, co, ov); end
    run4(4'h8, 4'h8, 1'b1, s, co, ov, lat);
    checks++; if ({s, co, ov} !== {4'h1, 2'b11}) begin errors++; $display("FAIL w4_neg_ovf: got %h/%b%b want 1/11", s, co, ov); end
  endtask

  task automatic test_back_to_back4;
    logic [3:0] av, bv, es;
    logic       ci, eco, eov;
    int         n, last;
    last = -1;
    out_ready4 = 1'b1;
    in_valid4  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (in_ready4 !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
      av = 4'($urandom()); bv = 4'($urandom()); ci = 1'($urandom_range(0, 1));
      {eco, es} = {1'b0, av} + {1'b0, bv} + {4'h0, ci};
      eov = (av[3] == bv[3]) && (es[3] != av[3]);
      a4 = av; b4 = bv; cin4 = ci;
      @(posedge clk); #1;
      n = 0;
      while (out_valid4 !== 1'b1 && n < 30) begin @(posedge clk); #1; n++; end
      checks++; if ({sum4, cout4, ovf4} !== {es, eco, eov}) begin errors++; $display("FAIL b2b4_result[%0d]: got %h/%b%b want %h/%b%b", k, sum4, cout4, ovf4, es, eco, eov); end
      if (k > 0) begin
        checks++; if (cyc - last != 3) begin errors++; $display("FAIL b2b4_interval[%0d]: got %0d want 3", k, cyc - last); end
      end
      last = cyc;
    end
    in_valid4 = 1'b0;
    @(posedge clk); #1;
    out_ready4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith16();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    test_width4();
    test_back_to_back4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunk_prefix_adder_seq.md
Name: chunk_prefix_adder_seq

Overview:
- Multi-cycle WIDTH-bit adder that sits directly downstream of the 4-bit prefix group-generate/propagate network and consumes its inclusive prefix P/G outputs.
- Processes one 4-bit chunk per clock, least-significant chunk first, and carries between chunks in a register.
- Uses a valid/ready handshake on both input and output.
- Serves area-constrained datapaths where a full-width prefix tree is too costly.

Parameters:
- WIDTH, 16, operand width in bits. Must be a multiple of CHUNK and at least 4.
- CHUNK, 4, bits processed per cycle. Fixed at 4 to match the prefix sub-module; not user-overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  addend A.
- b  input  WIDTH  addend B.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR cout.

Behaviour:
- Reset: rst is asynchronous and active-high. Asserting it forces state=IDLE, out_valid=0, sum=0, cout=0, ovf=0, chunk index=0, carry register=0. While rst is asserted, in_ready=0; in_ready goes to 1 on the first clk edge after release.
- States: IDLE, RUN, DONE. NCHUNK = WIDTH/CHUNK.
- IDLE:
  - in_ready=1.
  - On clk with in_valid&&in_ready: latch a, b, cin; carry register=cin; index=0; go to RUN.
- RUN:
  - in_ready=0.
  - Per cycle, take chunk k=index: p[i]=a[4k+i]^b[4k+i], g[i]=a&b (same bit), i=1..4.
  - Feed p/g to the prefix sub-module to obtain inclusive P[1..4], G[1..4].
  - Carry into bit 1 is c (the carry register). Carry into bit i>1 is G[i-1] | (P[i-1] & c).
  - sum chunk bit i = p[i] ^ (carry into bit i); write the chunk into the sum accumulator.
  - Next carry: c <= G[4] | (P[4] & c).
  - On the last chunk (index=NCHUNK-1): cout <= G[4] | (P[4] & c); ovf <= (carry into bit 4) ^ cout_next; go to DONE.
  - Otherwise index <= index+1.
- DONE:
  - out_valid=1; sum, cout and ovf are stable.
  - On out_ready, go to IDLE with out_valid=0.
  - in_ready=0 throughout DONE. Operands are not accepted until the state returns to IDLE, so the block has no overlap.
- Latency: the accept edge is T0. out_valid rises after edge T0+NCHUNK (4 cycles for WIDTH=16; 1 cycle for WIDTH=4). Minimum initiation interval is NCHUNK+2 cycles.
- sum and cout keep their last values after out_valid falls; they change only during RUN.
- An in_valid with no accept (RUN or DONE) has no effect; the input holds per the valid/ready protocol.
- rst mid-RUN or mid-DONE abandons the operation; no partial result is ever flagged valid.
- out_ready while out_valid=0 is ignored.
- Arithmetic is unsigned modulo 2^WIDTH; ovf is valid for the signed interpretation.

Decomposition:
- Shared package holds:
  - CHUNK_W=4 constant.
  - State typedef (IDLE/RUN/DONE).
  - A function returning NCHUNK and the index width, clog2(NCHUNK) with a minimum of 1.
- One sub-module: chunk_pg_prefix4. It is purely combinational: 4-bit p/g in, inclusive prefix P/G out, with G[i] = g[i] | (p[i] & G[i-1]). It is instantiated once and reused every RUN cycle.
- The FSM, index counter, carry register and sum accumulator stay in the top module.

Test Plan:
- a=0xFFFF, b=0x0001, cin=0 (WIDTH=16) -> sum=0x0000, cout=1, ovf=0; out_valid exactly 4 cycles after accept.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0. Then a=0x0FFF, b=0x0000, cin=1 -> sum=0x1000, checking carry rippling across three chunk boundaries.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid stays 1, sum/cout/ovf stable, in_ready stays 0 and a pending in_valid is not accepted. Raise out_ready -> IDLE next cycle, then the pending operand is accepted.
- Assert rst asynchronously mid-RUN (index=2) -> out_valid, sum and cout go to 0 immediately, state=IDLE. A new add of 0x0001+0x0001 -> sum=0x0002 with no contamination from the old carry.
- Back-to-back with in_valid and out_ready tied high: random pairs yield one result every 6 cycles, each matching a reference model; repeat with WIDTH=4 (1-cycle RUN).
